// File: rtl/ascon_perm_engine_pkg.sv
// Shared types, constants and helpers for the Ascon-p permutation engine.
package ascon_perm_engine_pkg;

    typedef logic [4:0][63:0] state_t;

    localparam int MAX_ROUNDS = 12;

    // Right-rotation pairs of the linear layer, indexed by state word x0..x4.
    localparam int unsigned ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ROT_B [5] = '{28, 39, 6, 17, 41};

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned s);
        logic [127:0] w;
        w = {x, x} >> s;
        return w[63:0];
    endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Request/response bundle between the accelerator and the permutation engine.
interface ascon_perm_engine_if
    import ascon_perm_engine_pkg::*;
#(
    parameter int ROUND_W = 4
);
    logic               start_i;
    logic [ROUND_W-1:0] rounds_i;
    state_t             state_i;
    logic               abort_i;
    logic               intr_en_i;
    logic               intr_clr_i;
    state_t             state_o;
    logic               busy_o;
    logic               done_o;
    logic               intr_o;

    modport master (
        output start_i, rounds_i, state_i, abort_i, intr_en_i, intr_clr_i,
        input  state_o, busy_o, done_o, intr_o
    );

    modport slave (
        input  start_i, rounds_i, state_i, abort_i, intr_en_i, intr_clr_i,
        output state_o, busy_o, done_o, intr_o
    );
endinterface

// File: rtl/ascon_perm_engine_round.sv
// One combinational Ascon-p round: constant addition, S-box layer, linear layer.
module ascon_perm_engine_round
    import ascon_perm_engine_pkg::*;
(
    input  state_t     st_i,
    input  logic [3:0] rnd_i,
    output state_t     st_o
);
    state_t x_s;
    state_t t_s;
    state_t a_s;
    state_t s_s;

    // Bit-sliced S-box, written in the reference in-place operation order.
    always_comb begin
        x_s       = st_i;
        x_s[2]    = st_i[2] ^ {56'd0, round_const(rnd_i)};
        x_s[0]    = x_s[0] ^ x_s[4];
        x_s[4]    = x_s[4] ^ x_s[3];
        x_s[2]    = x_s[2] ^ x_s[1];
        t_s[0]    = ~x_s[0] & x_s[1];
        t_s[1]    = ~x_s[1] & x_s[2];
        t_s[2]    = ~x_s[2] & x_s[3];
        t_s[3]    = ~x_s[3] & x_s[4];
        t_s[4]    = ~x_s[4] & x_s[0];
        a_s[0]    = x_s[0] ^ t_s[1];
        a_s[1]    = x_s[1] ^ t_s[2];
        a_s[2]    = x_s[2] ^ t_s[3];
        a_s[3]    = x_s[3] ^ t_s[4];
        a_s[4]    = x_s[4] ^ t_s[0];
        s_s[0]    = a_s[0] ^ a_s[4];
        s_s[1]    = a_s[1] ^ a_s[0];
        s_s[2]    = ~a_s[2];
        s_s[3]    = a_s[3] ^ a_s[2];
        s_s[4]    = a_s[4];
    end

    for (genvar i = 0; i < 5; i++) begin : g_lin
        assign st_o[i] = s_s[i] ^ ror64(s_s[i], ROT_A[i]) ^ ror64(s_s[i], ROT_B[i]);
    end

endmodule

// File: rtl/ascon_perm_engine.sv
// Ascon-p permutation engine: UNROLL chained rounds per clock, 0..12 rounds per
// request, start/done handshake with abort and a sticky maskable interrupt.
module ascon_perm_engine
    import ascon_perm_engine_pkg::*;
#(
    parameter int UNROLL  = 1,
    parameter int ROUND_W = 4
)(
    input  logic                clk_i,
    input  logic                rst_i,
    ascon_perm_engine_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 ||
          UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
        $error("ascon_perm_engine: UNROLL=%0d is not one of 1,2,3,4,6,12", UNROLL);
    end

    logic [1:0]         fsm_q, fsm_d;
    state_t             st_q, st_d;
    logic [3:0]         r_q, r_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               intr_q, intr_d;

    logic [ROUND_W-1:0] rounds_s;
    logic [3:0]         n_s;
    logic [4:0]         r_sum_s;
    logic [3:0]         r_nxt_s;
    state_t             final_s;

    assign rounds_s = bus.rounds_i;

    // Stage j runs round r+j; stages past the last round pass the state through.
    for (genvar j = 0; j < UNROLL; j++) begin : g_stage
        state_t     in_s;
        state_t     rnd_s;
        state_t     out_s;
        logic [4:0] idx_s;
        logic       en_s;

        if (j == 0) begin : g_first
            assign in_s = st_q;
        end else begin : g_next
            assign in_s = g_stage[j-1].out_s;
        end

        assign idx_s = {1'b0, r_q} + 5'(j);
        assign en_s  = (idx_s < 5'(MAX_ROUNDS));

        ascon_perm_engine_round u_round (
            .st_i  (in_s),
            .rnd_i (idx_s[3:0]),
            .st_o  (rnd_s)
        );

        assign out_s = en_s ? rnd_s : in_s;
    end

    assign final_s = g_stage[UNROLL-1].out_s;
    assign r_sum_s = {1'b0, r_q} + 5'(UNROLL);
    assign r_nxt_s = (r_sum_s >= 5'(MAX_ROUNDS)) ? 4'(MAX_ROUNDS) : r_sum_s[3:0];

    // Requested round count, clamped to a full permutation.
    always_comb begin
        if (32'(rounds_s) > 32'(MAX_ROUNDS)) begin
            n_s = 4'(MAX_ROUNDS);
        end else begin
            n_s = 4'(rounds_s);
        end
    end

    // Next-state logic for the sequencer, working state and interrupt.
    always_comb begin
        fsm_d = fsm_q;
        st_d  = st_q;
        r_d   = r_q;
        case (fsm_q)
            S_IDLE, S_DONE: begin
                if (bus.start_i) begin
                    st_d = bus.state_i;
                    r_d  = 4'(MAX_ROUNDS) - n_s;
                    if (n_s == 4'd0) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d = S_RUN;
                    end
                end else begin
                    fsm_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    fsm_d = S_IDLE;
                end else begin
                    st_d = final_s;
                    r_d  = r_nxt_s;
                    if (r_nxt_s == 4'(MAX_ROUNDS)) begin
                        fsm_d = S_DONE;
                    end else begin
                        fsm_d = S_RUN;
                    end
                end
            end
            default: begin
                fsm_d = S_IDLE;
            end
        endcase

        busy_d = (fsm_d == S_RUN);
        done_d = (fsm_d == S_DONE);

        // A completion in the same cycle as a clear keeps the interrupt raised.
        if (done_d && bus.intr_en_i) begin
            intr_d = 1'b1;
        end else if (bus.intr_clr_i) begin
            intr_d = 1'b0;
        end else begin
            intr_d = intr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            r_q    <= 4'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            r_q    <= r_d;
            busy_q <= busy_d;
            done_q <= done_d;
            intr_q <= intr_d;
        end
    end

    assign bus.state_o = st_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.intr_o  = intr_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Directed bench: one engine per legal UNROLL, all driven by the same stimulus,
// checked against a table-driven Ascon-p reference model.
module tb_ascon_perm_engine;
    import ascon_perm_engine_pkg::*;

    localparam int NDUT = 6;
    localparam int UNROLLS [NDUT] = '{1, 2, 3, 4, 6, 12};
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       intr_en = 1'b0;
    logic       intr_clr = 1'b0;
    logic [3:0] rounds = 4'd0;
    state_t     state_in = '0;

    state_t st_out [NDUT];
    logic   busy   [NDUT];
    logic   done   [NDUT];
    logic   intr   [NDUT];

    int     n_checks = 0;
    int     n_fail = 0;
    state_t res [NDUT];
    state_t res2 [NDUT];
    int     done_at [NDUT];
    int     done2_at [NDUT];
    int     busy_cnt [NDUT];
    state_t kat, kat_res, s1, s2, s3;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ascon_perm_engine_if #(.ROUND_W(4)) bus ();
        assign bus.start_i    = start;
        assign bus.rounds_i   = rounds;
        assign bus.state_i    = state_in;
        assign bus.abort_i    = abort;
        assign bus.intr_en_i  = intr_en;
        assign bus.intr_clr_i = intr_clr;
        ascon_perm_engine #(.UNROLL(UNROLLS[g]), .ROUND_W(4)) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
        assign st_out[g] = bus.state_o;
        assign busy[g]   = bus.busy_o;
        assign done[g]   = bus.done_o;
        assign intr[g]   = bus.intr_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
        logic [63:0] o;
        for (int b = 0; b < 64; b++) o[b] = v[(b + s) % 64];
        return o;
    endfunction

    function automatic state_t ref_round(input state_t s, input int i);
        state_t     x, y;
        logic [4:0] col;
        x = s;
        x[2][7:0] = x[2][7:0] ^ (8'hF0 - 8'(15 * i));
        for (int b = 0; b < 64; b++) begin
            col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
            col = SBOX[col];
            y[0][b] = col[4]; y[1][b] = col[3]; y[2][b] = col[2];
            y[3][b] = col[1]; y[4][b] = col[0];
        end
        x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
        x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
        x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
        x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
        x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
        return x;
    endfunction

    function automatic state_t ref_perm(input state_t s, input int first, input int cnt);
        state_t x;
        x = s;
        for (int k = 0; k < cnt; k++) x = ref_round(x, first + k);
        return x;
    endfunction

    // One start pulse, then watch every engine for 16 cycles after the start edge.
    task automatic run_all(input state_t s, input logic [3:0] rnd, input string tag);
        int n_eff, c_exp;
        state_in = s;
        rounds   = rnd;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            done_at[g] = 0; busy_cnt[g] = 0; res[g] = '0;
        end
        for (int c = 1; c <= 16; c++) begin
            for (int g = 0; g < NDUT; g++) begin
                if (busy[g]) busy_cnt[g]++;
                if (done[g] && done_at[g] == 0) begin
                    done_at[g] = c;
                    res[g]     = st_out[g];
                end
            end
            tick();
        end
        n_eff = (rnd > 4'd12) ? 12 : int'(rnd);
        for (int g = 0; g < NDUT; g++) begin
            c_exp = (n_eff + UNROLLS[g] - 1) / UNROLLS[g];
            check($sformatf("%s_done_u%0d", tag, UNROLLS[g]), done_at[g], c_exp + 1);
            check($sformatf("%s_busy_u%0d", tag, UNROLLS[g]), busy_cnt[g], c_exp);
            check($sformatf("%s_state_u%0d", tag, UNROLLS[g]), res[g],
                  ref_perm(s, 12 - n_eff, n_eff));
        end
    endtask

    initial begin
        kat    = '0;
        kat[0] = 64'h80400c0600000000;
        s1 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
              64'hdeadbeefcafef00d, 64'h1122334455667788};
        s2 = {64'hffffffffffffffff, 64'h0000000000000001, 64'h8000000000000000,
              64'h5555aaaa5555aaaa, 64'h0badc0de0badc0de};
        s3 = {64'h13579bdf2468ace0, 64'h0, 64'hcccccccccccccccc,
              64'h7766554433221100, 64'h00000000ffffffff};

        tick();
        tick();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst_state_u%0d", UNROLLS[g]), st_out[g], '0);
            check($sformatf("rst_flags_u%0d", UNROLLS[g]),
                  {busy[g], done[g], intr[g]}, 3'b000);
        end
        rst = 1'b0;

        // Reset asserted in cycle 5 of a 12-round run.
        state_in = kat; rounds = 4'd12; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("midrun_busy_before_rst", busy[0], 1'b1);
        rst = 1'b1;
        #1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("midrun_rst_state_u%0d", UNROLLS[g]), st_out[g], '0);
            check($sformatf("midrun_rst_flags_u%0d", UNROLLS[g]),
                  {busy[g], done[g], intr[g]}, 3'b000);
        end
        #2;
        rst = 1'b0;
        tick();
        check("midrun_idle_after_rst", {busy[0], done[0]}, 2'b00);

        run_all(kat, 4'd12, "kat");
        kat_res = res[0];
        check("kat_latency_u1", done_at[0], 13);
        check("kat_latency_u4", done_at[3], 4);
        check("kat_latency_u12", done_at[5], 2);
        for (int g = 1; g < NDUT; g++)
            check($sformatf("kat_vs_u1_u%0d", UNROLLS[g]), res[g], kat_res);

        run_all(s1, 4'd8, "n8");
        check("n8_u3_busy", busy_cnt[2], 3);
        check("n8_u3_vs_u1", res[2], res[0]);
        run_all(s2, 4'd6, "n6");
        check("n6_u4_busy", busy_cnt[3], 2);
        check("n6_u4_vs_u1", res[3], res[0]);

        run_all(s3, 4'd0, "n0");
        for (int g = 0; g < NDUT; g++)
            check($sformatf("n0_passthru_u%0d", UNROLLS[g]), res[g], s3);

        run_all(kat, 4'd15, "r15");
        for (int g = 0; g < NDUT; g++)
            check($sformatf("r15_vs_kat_u%0d", UNROLLS[g]), res[g], kat_res);

        // start held high: new state during RUN is ignored, then taken at DONE.
        state_in = s1; rounds = 4'd4; start = 1'b1;
        tick();
        state_in = s2;
        for (int g = 0; g < NDUT; g++) begin
            done_at[g] = 0; done2_at[g] = 0; res[g] = '0; res2[g] = '0;
        end
        for (int c = 1; c <= 12; c++) begin
            for (int g = 0; g < NDUT; g++) begin
                if (done[g] && done_at[g] == 0) begin
                    done_at[g] = c; res[g] = st_out[g];
                end else if (done[g] && done2_at[g] == 0) begin
                    done2_at[g] = c; res2[g] = st_out[g];
                end
            end
            tick();
        end
        start = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("b2b_done1_u%0d", UNROLLS[g]), done_at[g],
                  (4 + UNROLLS[g] - 1) / UNROLLS[g] + 1);
            check($sformatf("b2b_done2_u%0d", UNROLLS[g]), done2_at[g],
                  2 * ((4 + UNROLLS[g] - 1) / UNROLLS[g] + 1));
            check($sformatf("b2b_res1_u%0d", UNROLLS[g]), res[g], ref_perm(s1, 8, 4));
            check($sformatf("b2b_res2_u%0d", UNROLLS[g]), res2[g], ref_perm(s2, 8, 4));
        end
        for (int k = 0; k < 14; k++) tick();

        // Abort in RUN cycle 2 (the UNROLL=12 engine has already finished by then).
        state_in = s3; rounds = 4'd12; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            if (UNROLLS[g] < 12) begin
                check($sformatf("abort_flags_u%0d", UNROLLS[g]), {busy[g], done[g]}, 2'b00);
                check($sformatf("abort_partial_u%0d", UNROLLS[g]), st_out[g],
                      ref_perm(s3, 0, UNROLLS[g]));
            end
        end
        for (int g = 0; g < NDUT; g++) busy_cnt[g] = 0;
        for (int c = 0; c < 14; c++) begin
            for (int g = 0; g < NDUT; g++) if (done[g]) busy_cnt[g]++;
            tick();
        end
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("abort_intr_u%0d", UNROLLS[g]), intr[g], 1'b0);
            if (UNROLLS[g] < 12) begin
                check($sformatf("abort_nodone_u%0d", UNROLLS[g]), busy_cnt[g], 0);
                check($sformatf("abort_hold_u%0d", UNROLLS[g]), st_out[g],
                      ref_perm(s3, 0, UNROLLS[g]));
            end
        end

        // Interrupt: set on done, survives enable drop, set beats clear, clear alone.
        intr_en = 1'b1;
        run_all(s2, 4'd1, "irq");
        for (int g = 0; g < NDUT; g++)
            check($sformatf("irq_set_u%0d", UNROLLS[g]), intr[g], 1'b1);
        intr_en = 1'b0;
        tick();
        check("irq_sticky_en_off", intr[0], 1'b1);
        intr_en = 1'b1; intr_clr = 1'b1; start = 1'b1; rounds = 4'd0; state_in = s1;
        tick();
        start = 1'b0;
        for (int g = 0; g < NDUT; g++)
            check($sformatf("irq_set_wins_u%0d", UNROLLS[g]), {done[g], intr[g]}, 2'b11);
        tick();
        for (int g = 0; g < NDUT; g++)
            check($sformatf("irq_clear_u%0d", UNROLLS[g]), intr[g], 1'b0);
        intr_clr = 1'b0; intr_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("irq_masked_done", {done[0], intr[0]}, 2'b10);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
